// File: rtl/symbol_rr_detect_ctrl.sv
// symbol_rr_detect_ctrl: two-requester round-robin front end sharing one 01,10,11 symbol detector.
// Optional SYMBOL_RR_CLEAR_ON_HIT_EN: a completed match returns the context to S0 (non-overlapping).
`default_nettype none

module symbol_rr_detect_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_num,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_num,
  output logic             req1_ready,
  input  logic             flush0,
  input  logic             flush1,
  output logic             hit,
  output logic             hit_id,
  output logic [CNT_W-1:0] hit_cnt0,
  output logic [CNT_W-1:0] hit_cnt1
);

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           ctx0, ctx1, ctx0_next, ctx1_next;
  logic             last_grant, last_grant_next;
  logic             hit_next, hit_id_next;
  logic [CNT_W-1:0] cnt0_next, cnt1_next;
  logic             accept0, accept1, match0, match1;
  state_t           raw0, raw1;

  function automatic state_t advance(input state_t cur, input logic [1:0] num);
    state_t nxt;
    nxt = S0;
    if (num == 2'b01) begin
      nxt = S1;
    end else begin
      case (cur)
        S1:      nxt = (num == 2'b10) ? S2 : S0;
        S2:      nxt = (num == 2'b10) ? S2 : ((num == 2'b11) ? S3 : S0);
        S3:      nxt = (num == 2'b11) ? S3 : S0;
        default: nxt = S0;
      endcase
    end
    return nxt;
  endfunction

  // Detector state the context keeps after a completed match.
  function automatic state_t settle(input state_t raw);
`ifdef SYMBOL_RR_CLEAR_ON_HIT_EN
    return (raw == S3) ? S0 : raw;
`else
    return raw;
`endif
  endfunction

  // Arbitration stays combinational even in reset; contention goes to the requester not served last.
  always_comb begin
    req0_ready = req0_valid && (!req1_valid || last_grant);
    req1_ready = req1_valid && (!req0_valid || !last_grant);
  end

  always_comb begin
    accept0         = req0_valid && req0_ready;
    accept1         = req1_valid && req1_ready;
    raw0            = advance(ctx0, req0_num);
    raw1            = advance(ctx1, req1_num);
    match0          = 1'b0;
    match1          = 1'b0;
    ctx0_next       = ctx0;
    ctx1_next       = ctx1;
    last_grant_next = last_grant;
    hit_id_next     = hit_id;
    cnt0_next       = hit_cnt0;
    cnt1_next       = hit_cnt1;

    if (accept0) last_grant_next = 1'b0;
    else if (accept1) last_grant_next = 1'b1;

    // A flushed symbol is still handshaken but never reaches the detector.
    if (flush0) begin
      ctx0_next = S0;
    end else if (accept0) begin
      ctx0_next = settle(raw0);
      match0    = (raw0 == S3);
    end

    if (flush1) begin
      ctx1_next = S0;
    end else if (accept1) begin
      ctx1_next = settle(raw1);
      match1    = (raw1 == S3);
    end

    hit_next = match0 || match1;
    if (match0) begin
      hit_id_next = 1'b0;
      if (hit_cnt0 != CNT_MAX) cnt0_next = hit_cnt0 + 1'b1;
    end
    if (match1) begin
      hit_id_next = 1'b1;
      if (hit_cnt1 != CNT_MAX) cnt1_next = hit_cnt1 + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctx0       <= S0;
      ctx1       <= S0;
      last_grant <= 1'b1;
      hit        <= 1'b0;
      hit_id     <= 1'b0;
      hit_cnt0   <= '0;
      hit_cnt1   <= '0;
    end else begin
      ctx0       <= ctx0_next;
      ctx1       <= ctx1_next;
      last_grant <= last_grant_next;
      hit        <= hit_next;
      hit_id     <= hit_id_next;
      hit_cnt0   <= cnt0_next;
      hit_cnt1   <= cnt1_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_symbol_rr_detect_ctrl.sv
// Directed self-checking bench for symbol_rr_detect_ctrl (CNT_W=8 main instance, CNT_W=2 saturation instance).
`default_nettype none

module tb_symbol_rr_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       v0, v1, f0, f1;
  logic [1:0] n0, n1;
  logic       r0, r1, hit, hit_id;
  logic [7:0] cnt0, cnt1;

  logic       s_v0, s_f0;
  logic [1:0] s_n0;
  logic       s_r0, s_r1, s_hit, s_hit_id;
  logic [1:0] s_cnt0, s_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  symbol_rr_detect_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_num(n0), .req0_ready(r0),
    .req1_valid(v1), .req1_num(n1), .req1_ready(r1),
    .flush0(f0), .flush1(f1),
    .hit(hit), .hit_id(hit_id), .hit_cnt0(cnt0), .hit_cnt1(cnt1)
  );

  symbol_rr_detect_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req0_valid(s_v0), .req0_num(s_n0), .req0_ready(s_r0),
    .req1_valid(1'b0), .req1_num(2'b00), .req1_ready(s_r1),
    .flush0(s_f0), .flush1(1'b0),
    .hit(s_hit), .hit_id(s_hit_id), .hit_cnt0(s_cnt0), .hit_cnt1(s_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle on the main instance: check readies before the edge, hit/hit_id after it.
  task automatic step(input string tag,
                      input logic a0, input logic [1:0] a_n0,
                      input logic a1, input logic [1:0] a_n1,
                      input logic a_f0, input logic a_f1,
                      input logic e_r0, input logic e_r1,
                      input logic e_hit, input logic e_id);
    v0 = a0; n0 = a_n0; v1 = a1; n1 = a_n1; f0 = a_f0; f1 = a_f1;
    #1;
    chk({tag, ".ready0"}, {31'd0, r0}, {31'd0, e_r0});
    chk({tag, ".ready1"}, {31'd0, r1}, {31'd0, e_r1});
    @(posedge clk); #1;
    chk({tag, ".hit"}, {31'd0, hit}, {31'd0, e_hit});
    if (e_hit) chk({tag, ".hit_id"}, {31'd0, hit_id}, {31'd0, e_id});
  endtask

  task automatic sat_step(input string tag, input logic [1:0] num, input logic e_hit, input logic [1:0] e_cnt);
    s_v0 = 1'b1; s_n0 = num; s_f0 = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".hit"}, {31'd0, s_hit}, {31'd0, e_hit});
    chk({tag, ".cnt0"}, {30'd0, s_cnt0}, {30'd0, e_cnt});
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; f0 = 0; f1 = 0; n0 = 0; n1 = 0;
    s_v0 = 0; s_n0 = 0; s_f0 = 0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst.hit", {31'd0, hit}, 32'd0);
    chk("rst.hit_id", {31'd0, hit_id}, 32'd0);
    chk("rst.cnt0", {24'd0, cnt0}, 32'd0);
    chk("rst.cnt1", {24'd0, cnt1}, 32'd0);

    // Requester 0 alone
    step("solo0.a", 1, 2'b01, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    step("solo0.b", 1, 2'b10, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    step("solo0.c", 1, 2'b11, 0, 2'b00, 0, 0, 1, 0, 1, 0);
    chk("solo0.cnt0", {24'd0, cnt0}, 32'd1);
    chk("solo0.cnt1", {24'd0, cnt1}, 32'd0);

    // Continuous contention from a fresh reset: grants alternate starting with 0
    do_reset();
    step("cont.1", 1, 2'b01, 1, 2'b01, 0, 0, 1, 0, 0, 0);
    step("cont.2", 1, 2'b10, 1, 2'b01, 0, 0, 0, 1, 0, 0);
    step("cont.3", 1, 2'b10, 1, 2'b10, 0, 0, 1, 0, 0, 0);
    step("cont.4", 1, 2'b11, 1, 2'b10, 0, 0, 0, 1, 0, 0);
    step("cont.5", 1, 2'b11, 1, 2'b11, 0, 0, 1, 0, 1, 0);
    step("cont.6", 1, 2'b00, 1, 2'b11, 0, 0, 0, 1, 1, 1);
    step("cont.idle", 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("cont.id_hold", {31'd0, hit_id}, 32'd1);
    chk("cont.cnt0", {24'd0, cnt0}, 32'd1);
    chk("cont.cnt1", {24'd0, cnt1}, 32'd1);

    // Requester 1: restart within a partial match, then a broken sequence
    step("r1.a", 0, 2'b00, 1, 2'b01, 0, 0, 0, 1, 0, 0);
    step("r1.b", 0, 2'b00, 1, 2'b10, 0, 0, 0, 1, 0, 0);
    step("r1.c", 0, 2'b00, 1, 2'b01, 0, 0, 0, 1, 0, 0);
    step("r1.d", 0, 2'b00, 1, 2'b10, 0, 0, 0, 1, 0, 0);
    step("r1.e", 0, 2'b00, 1, 2'b11, 0, 0, 0, 1, 1, 1);
    step("r1.f", 0, 2'b00, 1, 2'b01, 0, 0, 0, 1, 0, 0);
    step("r1.g", 0, 2'b00, 1, 2'b00, 0, 0, 0, 1, 0, 0);
    step("r1.h", 0, 2'b00, 1, 2'b10, 0, 0, 0, 1, 0, 0);
    step("r1.i", 0, 2'b00, 1, 2'b11, 0, 0, 0, 1, 0, 0);
    chk("r1.cnt1", {24'd0, cnt1}, 32'd2);

    // Flush coinciding with the completing symbol discards it
    step("fl.a", 1, 2'b01, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    step("fl.b", 1, 2'b10, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    step("fl.c", 1, 2'b11, 0, 2'b00, 1, 0, 1, 0, 0, 0);
    step("fl.d", 1, 2'b11, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    chk("fl.cnt0", {24'd0, cnt0}, 32'd1);

    // Overlapping match: 01,10,11,11
    step("ov.a", 1, 2'b01, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    step("ov.b", 1, 2'b10, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    step("ov.c", 1, 2'b11, 0, 2'b00, 0, 0, 1, 0, 1, 0);
`ifdef SYMBOL_RR_CLEAR_ON_HIT_EN
    step("ov.d", 1, 2'b11, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    chk("ov.cnt0", {24'd0, cnt0}, 32'd2);
`else
    step("ov.d", 1, 2'b11, 0, 2'b00, 0, 0, 1, 0, 1, 0);
    chk("ov.cnt0", {24'd0, cnt0}, 32'd3);
`endif

    // Mid-stream reset wipes contexts and counters
    step("mr.a", 1, 2'b01, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    step("mr.b", 1, 2'b10, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    do_reset();
    chk("mr.cnt0", {24'd0, cnt0}, 32'd0);
    chk("mr.cnt1", {24'd0, cnt1}, 32'd0);
    chk("mr.hit", {31'd0, hit}, 32'd0);
    step("mr.c", 1, 2'b11, 0, 2'b00, 0, 0, 1, 0, 0, 0);

    // 2-bit counter saturation on the second instance
    sat_step("sat.a", 2'b01, 1'b0, 2'd0);
    sat_step("sat.b", 2'b10, 1'b0, 2'd0);
`ifdef SYMBOL_RR_CLEAR_ON_HIT_EN
    sat_step("sat.c", 2'b11, 1'b1, 2'd1);
    sat_step("sat.d", 2'b11, 1'b0, 2'd1);
    sat_step("sat.e", 2'b11, 1'b0, 2'd1);
    sat_step("sat.f", 2'b11, 1'b0, 2'd1);
    sat_step("sat.g", 2'b11, 1'b0, 2'd1);
`else
    sat_step("sat.c", 2'b11, 1'b1, 2'd1);
    sat_step("sat.d", 2'b11, 1'b1, 2'd2);
    sat_step("sat.e", 2'b11, 1'b1, 2'd3);
    sat_step("sat.f", 2'b11, 1'b1, 2'd3);
    sat_step("sat.g", 2'b11, 1'b1, 2'd3);
`endif
    s_v0 = 1'b0;
    @(posedge clk); #1;
    chk("sat.idle_hit", {31'd0, s_hit}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
